// File: rtl/modn_counter_pkg.sv
// rtl/modn_counter_pkg.sv - shared direction constants and sizing helper for the mod-N counter
package modn_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divide-by-DIV enable prescaler; TICK marks the last phase of each interval
module tick_prescaler
  import modn_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic Clk,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic TICK
);

  // Keep at least one bit so DIV=1 still elaborates; the counter then sits at 0.
  localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (RST || CLR) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - modulo-N up/down counter with load clamp and registered TC
// Optional prescaler built when MODN_COUNTER_PRESCALE_EN is defined.
module modn_updown_counter
  import modn_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int DIV     = 1
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] OUT,
  output logic             TC
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic             tick;
  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] load_clamped;

`ifdef MODN_COUNTER_PRESCALE_EN
  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .Clk  (Clk),
    .RST  (RST),
    .CLR  (LOAD),
    .EN   (EN),
    .TICK (tick)
  );
`else
  logic unused_div;
  assign unused_div = (DIV > 0);
  assign tick       = 1'b1;
`endif

  assign step = EN & tick;

  // Compare one bit wider so MODULUS = 2^WIDTH is representable.
  always_comb begin
    load_clamped = ((WIDTH+1)'(LOAD_VAL) < (WIDTH+1)'(MODULUS)) ? LOAD_VAL : MAXV;
    wrap         = 1'b0;
    next_val     = OUT;
    if (DIR == DIR_DOWN) begin
      wrap     = (OUT == '0);
      next_val = wrap ? MAXV : OUT - WIDTH'(1);
    end else begin
      wrap     = (OUT == MAXV);
      next_val = wrap ? '0 : OUT + WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      OUT <= '0;
      TC  <= 1'b0;
    end else if (LOAD) begin
      OUT <= load_clamped;
      TC  <= 1'b0;
    end else if (step) begin
      OUT <= next_val;
      TC  <= wrap;
    end else begin
      TC  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modn_updown_counter.sv
// tb/tb_modn_updown_counter.sv - directed self-checking bench for modn_updown_counter
module tb_modn_updown_counter;
  import modn_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, dir, load;
  logic [3:0] load_val;
  logic [3:0] out;
  logic       tc;

  logic       p_rst, p_en, p_dir, p_load;
  logic [3:0] p_load_val;
  logic [3:0] p_out;
  logic       p_tc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) dut (
    .Clk(clk), .RST(rst), .EN(en), .DIR(dir), .LOAD(load),
    .LOAD_VAL(load_val), .OUT(out), .TC(tc)
  );

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(4)) dut_pre (
    .Clk(clk), .RST(p_rst), .EN(p_en), .DIR(p_dir), .LOAD(p_load),
    .LOAD_VAL(p_load_val), .OUT(p_out), .TC(p_tc)
  );

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dir = DIR_UP; load = 1'b0; load_val = 4'd0;
    p_rst = 1'b1; p_en = 1'b0; p_dir = DIR_UP; p_load = 1'b0; p_load_val = 4'd0;

    // Reset held two cycles with EN high
    tick_clk(); chk("rst1_out", out, 0); chk("rst1_tc", tc, 0);
    tick_clk(); chk("rst2_out", out, 0); chk("rst2_tc", tc, 0);
    rst = 1'b0;
    tick_clk(); chk("post_rst_out", out, 1); chk("post_rst_tc", tc, 0);

    // Up wrap at MODULUS=10
    rst = 1'b1; tick_clk(); rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick_clk(); chk($sformatf("up_out_%0d", i), out, i); chk($sformatf("up_tc_%0d", i), tc, 0);
    end
    tick_clk(); chk("up_wrap_out", out, 0); chk("up_wrap_tc", tc, 1);
    tick_clk(); chk("up_after_out", out, 1); chk("up_after_tc", tc, 0);

    // Down wrap from 0
    rst = 1'b1; tick_clk(); rst = 1'b0; dir = DIR_DOWN;
    tick_clk(); chk("dn_wrap_out", out, 9); chk("dn_wrap_tc", tc, 1);
    tick_clk(); chk("dn_8_out", out, 8); chk("dn_8_tc", tc, 0);
    tick_clk(); chk("dn_7_out", out, 7);

    // Loads, including clamp
    en = 1'b0; load = 1'b1; load_val = 4'd5;
    tick_clk(); chk("load5_out", out, 5); chk("load5_tc", tc, 0);
    load_val = 4'd12;
    tick_clk(); chk("load12_out", out, 9);
    load_val = 4'd15;
    tick_clk(); chk("load15_out", out, 9);
    // OUT=9 with up step pending would wrap; load must win with no TC
    en = 1'b1; dir = DIR_UP; load_val = 4'd3;
    tick_clk(); chk("load_en_out", out, 3); chk("load_en_tc", tc, 0);
    load = 1'b0;

    // Enable hold and direction flip
    tick_clk(); chk("en_4_out", out, 4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_clk(); chk($sformatf("hold_out_%0d", i), out, 4); chk($sformatf("hold_tc_%0d", i), tc, 0);
    end
    en = 1'b1;
    tick_clk(); chk("dir_up_out", out, 5);
    dir = DIR_DOWN;
    tick_clk(); chk("dir_dn_out", out, 4);

    // Reset beats load and enable mid-count
    rst = 1'b1; load = 1'b1; load_val = 4'd6;
    tick_clk(); chk("rst_mid_out", out, 0); chk("rst_mid_tc", tc, 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

`ifdef MODN_COUNTER_PRESCALE_EN
    // Prescaled instance, DIV=4
    p_rst = 1'b1; tick_clk(); p_rst = 1'b0; p_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick_clk(); chk($sformatf("pre_wait_%0d", i), p_out, 0);
    end
    tick_clk(); chk("pre_step1", p_out, 1);
    tick_clk(); chk("pre_e5", p_out, 1);
    tick_clk(); chk("pre_e6", p_out, 1);
    p_en = 1'b0;
    tick_clk(); chk("pre_frz1", p_out, 1);
    tick_clk(); chk("pre_frz2", p_out, 1);
    p_en = 1'b1;
    tick_clk(); chk("pre_e9", p_out, 1);
    tick_clk(); chk("pre_step2", p_out, 2);
    tick_clk(); chk("pre_e11", p_out, 2);
    p_load = 1'b1; p_load_val = 4'd7;
    tick_clk(); chk("pre_load", p_out, 7);
    p_load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick_clk(); chk($sformatf("pre_ld_wait_%0d", i), p_out, 7);
    end
    tick_clk(); chk("pre_ld_step", p_out, 8);
`else
    // Prescaler not built: DIV is ignored, one step per enabled clock
    p_rst = 1'b1; tick_clk(); p_rst = 1'b0; p_en = 1'b1;
    tick_clk(); chk("nopre_step1", p_out, 1);
    tick_clk(); chk("nopre_step2", p_out, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modn_updown_counter.md
# modn_updown_counter

Parametrised successor to the 4-bit up-counter: a modulo-N up/down counter with configurable width, count enable, synchronous parallel load, and a registered terminal-count pulse. An optional built-in prescaler slows the count rate to one step every DIV clocks. It serves as the general counter/timebase for display, timer and sequencing blocks.

## Interface
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count range 0..MODULUS-1. Legal range 2 ≤ MODULUS ≤ 2^WIDTH.
- DIV, 1: prescale ratio; one count step per DIV enabled clocks. Must be ≥ 1; used only with the prescaler compiled in.
- Clk  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable.
- DIR  in  1  direction: 1 = up, 0 = down.
- LOAD  in  1  synchronous parallel load.
- LOAD_VAL  in  WIDTH  value to load.
- OUT  out  WIDTH  current count.
- TC  out  1  terminal-count pulse, one Clk cycle wide.

## Operation
- Priority on each rising edge: RST > LOAD > count step > hold.
- RST: OUT=0, TC=0, prescaler counter=0.
- LOAD: OUT=LOAD_VAL when LOAD_VAL < MODULUS, otherwise OUT=MODULUS-1.
  - LOAD clears the prescaler.
  - TC=0 on a load.
- Count step when EN=1 and tick=1:
  - Up: OUT==MODULUS-1 → 0, otherwise OUT+1.
  - Down: OUT==0 → MODULUS-1, otherwise OUT-1.
- TC is registered. It is 1 only in the cycle following the edge that performed a wrap, in either direction. It is 0 in all other cycles.
- EN=0: OUT holds, the prescaler holds, and TC=0 on the next edge.
- DIR is sampled on every step edge, so a direction change takes effect at the next step.
- Arithmetic is performed on WIDTH bits. When MODULUS=2^WIDTH, wrap behaviour equals natural overflow/underflow.

## Timing
- Reset values: OUT=0, TC=0.
- Latency is one Clk from the qualifying edge to the OUT update. TC coincides with OUT showing the wrapped value.
- Without the prescaler, tick is tied to 1, giving one step per enabled clock.
- With the prescaler:
  - The internal counter counts 0..DIV-1 while EN=1.
  - tick=1 when the counter equals DIV-1. The counter then returns to 0.
  - After RST or LOAD, the first step occurs on the DIV-th rising edge with EN=1.
  - DIV=1 behaves identically to the no-prescaler build.
- Simultaneous LOAD and step: LOAD wins, and no TC is generated.
- RST asserted mid-count: state clears on that edge, regardless of EN or LOAD.

## Configuration
- Macro: MODN_COUNTER_PRESCALE_EN.
- Defined: the prescaler sub-module is instantiated and DIV is honoured.
- Undefined: no prescaler logic is built, tick=1, and DIV is ignored.

## Structure
- Shared package `modn_counter_pkg` holds:
  - the direction constants DIR_UP=1 and DIR_DOWN=0;
  - a function clog2 for sizing the prescaler counter.
- Sub-module `tick_prescaler` has ports Clk, RST, CLR, EN and TICK, and a parameter DIV.
- The top level holds the count register, the TC register and the load clamp.

## Test plan
- Reset: hold RST=1 for 2 cycles with EN=1. Required: OUT=0 and TC=0 throughout. After release, the first step gives OUT=1.
- Up wrap, MODULUS=10, DIR=1, EN=1 from OUT=0: OUT steps 0…9 then 0. TC=1 only in the cycle OUT=0 after 9.
- Down wrap, MODULUS=10, DIR=0 from OUT=0: OUT goes 9, 8, …, with TC=1 in the cycle OUT first shows 9.
- Load:
  - LOAD=1 with LOAD_VAL=5 gives OUT=5 with TC=0.
  - LOAD_VAL=12 with MODULUS=10 gives OUT=9.
  - LOAD and EN together give OUT=LOAD_VAL.
- Enable and direction: toggling EN=0 for 3 cycles holds OUT. Flipping DIR at OUT=4 yields 5 then 4.
- Prescaler (macro defined, DIV=4): after RST, OUT increments on every 4th clock. Dropping EN freezes the phase. LOAD restarts a full 4-clock interval.
